reaction_timer_ctrl: RTL and testbench
======================================

Name: reaction_timer_ctrl

Overview:
- Top-level sequencer for the reaction-timer game built around the starting-line delay circuit.
- Launches a start sequence by pulsing the starting-line trigger, then waits for lights-out, which is the delay-complete pulse.
- Measures the player's reaction time in ms ticks and flags false starts and timeouts.
- Holds the last result and tracks the best valid time for the 7-segment display path.

Parameters:
- TIME_W, 14, width of reaction/best time counters in ticks (max 16383).
- TIMEOUT, 2000, ticks after lights-out with no reaction before a timeout result; must satisfy 1 <= TIMEOUT < 2**TIME_W.

Ports:
- i_clk  input  1  system clock.
- i_arst  input  1  reset; asynchronous, active-high.
- i_tick  input  1  1 ms enable, single-cycle, synchronous to i_clk.
- i_start  input  1  debounced single-cycle start-button pulse.
- i_react  input  1  debounced single-cycle reaction-button pulse.
- i_lineIdle  input  1  high while the starting-line FSM is idle (its PRBS-enable output).
- i_lightsOut  input  1  single-cycle delay-complete pulse from the starting-line circuit.
- i_clearBest  input  1  single-cycle pulse; resets the best time.
- o_trigger  output  1  single-cycle pulse to the starting-line trigger input.
- o_busy  output  1  high in ARMED or TIMING.
- o_resultValid  output  1  high in RESULT with a valid (non-fault) time.
- o_falseStart  output  1  high in FAULT when the cause was a false start.
- o_timeout  output  1  high in FAULT when the cause was a timeout.
- o_reactTime  output  TIME_W  last measured time, held until next run.
- o_bestTime  output  TIME_W  best valid time; all-ones means none recorded.

Behaviour:
- States: IDLE, ARMED, TIMING, RESULT, FAULT. All state and output registers reset asynchronously.
- Reset values: state=IDLE, o_trigger=0, flags=0, o_reactTime=0, o_bestTime='1, internal counter=0.
- Start acceptance: i_start is accepted only in IDLE, RESULT or FAULT, and only when i_lineIdle=1. Otherwise it is ignored, with no queuing.
- On an accepted start:
  - next state = ARMED;
  - o_trigger is registered high for exactly 1 cycle (the cycle the state is ARMED);
  - counter, o_reactTime and the falseStart/timeout flags are cleared;
  - o_resultValid drops.
- ARMED:
  - i_react=1 -> FAULT with falseStart=1. This includes i_react and i_lightsOut in the same cycle (a false start takes precedence).
  - Else i_lightsOut=1 -> TIMING with counter=0.
  - i_tick is ignored in ARMED.
- TIMING:
  - Priority order: i_react, then timeout, then tick.
  - i_react=1 -> RESULT, o_reactTime=counter. A tick arriving in the same cycle is not counted.
  - Else if i_tick=1 and counter==TIMEOUT-1 -> FAULT with timeout=1, o_reactTime=TIMEOUT.
  - Else if i_tick=1 -> counter+1.
- Best-time update, on the TIMING->RESULT transition:
  - if counter < o_bestTime, then o_bestTime <= counter on the same edge;
  - a time equal to the best does not update it;
  - faults never update o_bestTime.
- i_clearBest sets o_bestTime='1 in any state. If it coincides with a best-time update, the update wins.
- A reaction of 0 ticks (react before the first tick after lights-out) is a valid result of 0.
- In FAULT, late i_lightsOut pulses (the starting line still completing its delay after a false start) are ignored. i_react is ignored in IDLE, RESULT and FAULT.
- Reset mid-run returns to IDLE immediately. No o_trigger is emitted.
- Counter arithmetic is unsigned TIME_W bits. It cannot wrap because the timeout bounds it below 2**TIME_W.
- Latency: every input-to-output response is 1 cycle (all outputs registered). No combinational paths from inputs to outputs.

Test Plan:
- Normal run: reset, i_lineIdle=1, pulse i_start -> one-cycle o_trigger, o_busy=1. Lights-out, then 250 ticks, then i_react -> o_resultValid=1, o_reactTime=250, o_bestTime=250.
- Best tracking: runs of 300 then 180 then 180 -> o_bestTime 250, 180, 180 (equal value, no update). i_clearBest -> o_bestTime=16383.
- False start: i_react in ARMED; also i_react coincident with i_lightsOut -> o_falseStart=1, o_resultValid=0, o_bestTime unchanged. Subsequent i_lightsOut is ignored and the state stays FAULT.
- Timeout: TIMEOUT=2000, no react after lights-out -> on the 2000th tick o_timeout=1, o_reactTime=2000, o_busy=0.
- Start gating: i_start while i_lineIdle=0 or while ARMED -> no o_trigger, no state change. i_start at the same time as tick/react in RESULT -> restart to ARMED.
- Reset mid-TIMING at count 57 -> all outputs at reset values next cycle. Then a fresh run measures from 0 correctly.

Source files
------------

// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer game sequencer: triggers the starting line, waits for lights-out,
// times the player's reaction in tick units and keeps the best valid result.
module reaction_timer_ctrl #(
  parameter int TIME_W  = 14,
  parameter int TIMEOUT = 2000
) (
  input  logic              i_clk,
  input  logic              i_arst,
  input  logic              i_tick,
  input  logic              i_start,
  input  logic              i_react,
  input  logic              i_lineIdle,
  input  logic              i_lightsOut,
  input  logic              i_clearBest,
  output logic              o_trigger,
  output logic              o_busy,
  output logic              o_resultValid,
  output logic              o_falseStart,
  output logic              o_timeout,
  output logic [TIME_W-1:0] o_reactTime,
  output logic [TIME_W-1:0] o_bestTime
);

  typedef enum logic [2:0] {IDLE, ARMED, TIMING, RESULT, FAULT} state_t;

  localparam logic [TIME_W-1:0] LAST_TICK   = TIME_W'(TIMEOUT - 1);
  localparam logic [TIME_W-1:0] TIMEOUT_VAL = TIME_W'(TIMEOUT);

  state_t            state_reg;
  logic [TIME_W-1:0] count_reg;
  logic              start_ok;

  assign start_ok = i_start && i_lineIdle &&
                    ((state_reg == IDLE) || (state_reg == RESULT) || (state_reg == FAULT));

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      o_trigger     <= 1'b0;
      o_busy        <= 1'b0;
      o_resultValid <= 1'b0;
      o_falseStart  <= 1'b0;
      o_timeout     <= 1'b0;
      o_reactTime   <= '0;
      o_bestTime    <= '1;
    end else begin
      o_trigger <= 1'b0;
      // A best-time update later in this block overrides the clear.
      if (i_clearBest) o_bestTime <= '1;

      if (start_ok) begin
        state_reg     <= ARMED;
        o_trigger     <= 1'b1;
        o_busy        <= 1'b1;
        count_reg     <= '0;
        o_reactTime   <= '0;
        o_resultValid <= 1'b0;
        o_falseStart  <= 1'b0;
        o_timeout     <= 1'b0;
      end else begin
        case (state_reg)
          ARMED: begin
            if (i_react) begin
              state_reg    <= FAULT;
              o_falseStart <= 1'b1;
              o_busy       <= 1'b0;
            end else if (i_lightsOut) begin
              state_reg <= TIMING;
              count_reg <= '0;
            end
          end
          TIMING: begin
            if (i_react) begin
              state_reg     <= RESULT;
              o_resultValid <= 1'b1;
              o_busy        <= 1'b0;
              o_reactTime   <= count_reg;
              if (count_reg < o_bestTime) o_bestTime <= count_reg;
            end else if (i_tick && (count_reg == LAST_TICK)) begin
              state_reg   <= FAULT;
              o_timeout   <= 1'b1;
              o_busy      <= 1'b0;
              o_reactTime <= TIMEOUT_VAL;
            end else if (i_tick) begin
              count_reg <= count_reg + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Self-checking bench: directed game scenarios plus random traffic, all compared
// every cycle against a behavioural model of the game rules.
module tb_reaction_timer_ctrl;
  localparam int TIME_W  = 14;
  localparam int TIMEOUT = 2000;
  localparam int NONE    = (1 << TIME_W) - 1;

  logic i_clk = 1'b0, i_arst = 1'b0;
  logic i_tick = 0, i_start = 0, i_react = 0, i_lineIdle = 1, i_lightsOut = 0, i_clearBest = 0;
  logic o_trigger, o_busy, o_resultValid, o_falseStart, o_timeout;
  logic [TIME_W-1:0] o_reactTime, o_bestTime;

  reaction_timer_ctrl #(.TIME_W(TIME_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_arst(i_arst), .i_tick(i_tick), .i_start(i_start),
    .i_react(i_react), .i_lineIdle(i_lineIdle), .i_lightsOut(i_lightsOut),
    .i_clearBest(i_clearBest), .o_trigger(o_trigger), .o_busy(o_busy),
    .o_resultValid(o_resultValid), .o_falseStart(o_falseStart), .o_timeout(o_timeout),
    .o_reactTime(o_reactTime), .o_bestTime(o_bestTime)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0, n_pass = 0;

  // Game model: what the player has done so far, not how the RTL sequences it.
  bit waiting_lights, measuring, have_result, false_start, timed_out, trig;
  int elapsed, last_time, best;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    waiting_lights = 0; measuring = 0; have_result = 0;
    false_start = 0; timed_out = 0; trig = 0;
    elapsed = 0; last_time = 0; best = NONE;
  endtask

  task automatic model_step(input bit s, r, t, lo, li, cb);
    bit run_active;
    run_active = waiting_lights || measuring;
    trig = s && li && !run_active;
    if (cb) best = NONE;
    if (trig) begin
      waiting_lights = 1; measuring = 0; have_result = 0;
      false_start = 0; timed_out = 0; elapsed = 0; last_time = 0;
    end else if (waiting_lights) begin
      if (r) begin waiting_lights = 0; false_start = 1; end
      else if (lo) begin waiting_lights = 0; measuring = 1; elapsed = 0; end
    end else if (measuring) begin
      if (r) begin
        measuring = 0; have_result = 1; last_time = elapsed;
        if (elapsed < best) best = elapsed;
      end else if (t) begin
        if (elapsed + 1 == TIMEOUT) begin
          measuring = 0; timed_out = 1; last_time = TIMEOUT;
        end else elapsed++;
      end
    end
  endtask

  task automatic compare_all();
    chk("trigger", int'(o_trigger), int'(trig));
    chk("busy", int'(o_busy), int'(waiting_lights || measuring));
    chk("resultValid", int'(o_resultValid), int'(have_result));
    chk("falseStart", int'(o_falseStart), int'(false_start));
    chk("timeout", int'(o_timeout), int'(timed_out));
    chk("reactTime", int'(o_reactTime), last_time);
    chk("bestTime", int'(o_bestTime), best);
  endtask

  // Drive one cycle of inputs, clock it, then advance the model and compare.
  task automatic step(input bit s = 0, r = 0, t = 0, lo = 0, li = 1, cb = 0);
    i_start = s; i_react = r; i_tick = t; i_lightsOut = lo; i_lineIdle = li; i_clearBest = cb;
    @(posedge i_clk);
    #1;
    model_step(s, r, t, lo, li, cb);
    compare_all();
  endtask

  task automatic do_reset();
    i_arst = 1;
    i_start = 0; i_react = 0; i_tick = 0; i_lightsOut = 0; i_clearBest = 0; i_lineIdle = 1;
    #1;
    model_reset();
    compare_all();
    @(posedge i_clk);
    #1;
    compare_all();
    @(negedge i_clk);
    i_arst = 0;
  endtask

  task automatic play(input int ticks);
    step(.s(1));
    step(.lo(1));
    repeat (ticks) step(.t(1));
    step(.r(1));
  endtask

  initial begin
    model_reset();
    do_reset();
    chk("reset_best", int'(o_bestTime), NONE);
    chk("reset_react", int'(o_reactTime), 0);

    // Normal run
    step(.s(1));
    chk("normal_trigger", int'(o_trigger), 1);
    chk("normal_busy", int'(o_busy), 1);
    step();
    chk("trigger_one_cycle", int'(o_trigger), 0);
    step(.lo(1));
    repeat (250) step(.t(1));
    step(.r(1));
    chk("normal_valid", int'(o_resultValid), 1);
    chk("normal_time", int'(o_reactTime), 250);
    chk("normal_best", int'(o_bestTime), 250);
    chk("model_best", best, 250);

    // Best tracking
    play(300); chk("best_after_300", int'(o_bestTime), 250);
    play(180); chk("best_after_180", int'(o_bestTime), 180);
    play(180); chk("best_equal_180", int'(o_bestTime), 180);
    chk("react_equal_180", int'(o_reactTime), 180);

    // False starts
    step(.s(1));
    step(.r(1));
    chk("fs_flag", int'(o_falseStart), 1);
    chk("fs_valid", int'(o_resultValid), 0);
    chk("fs_best", int'(o_bestTime), 180);
    step(.lo(1));
    step(.t(1));
    chk("fs_late_lights", int'(o_falseStart), 1);
    chk("fs_busy", int'(o_busy), 0);
    step(.s(1));
    step(.r(1), .lo(1));
    chk("fs_coincident", int'(o_falseStart), 1);

    step(.cb(1));
    chk("clear_best", int'(o_bestTime), NONE);

    // Zero-tick reaction is valid
    play(0);
    chk("zero_valid", int'(o_resultValid), 1);
    chk("zero_best", int'(o_bestTime), 0);
    step(.cb(1));

    // Timeout
    step(.s(1));
    step(.lo(1));
    repeat (TIMEOUT - 1) step(.t(1));
    chk("to_not_yet", int'(o_timeout), 0);
    step(.t(1));
    chk("to_flag", int'(o_timeout), 1);
    chk("to_time", int'(o_reactTime), 2000);
    chk("to_busy", int'(o_busy), 0);

    // Start gating
    step(.s(1), .li(0));
    chk("gate_lineidle", int'(o_trigger), 0);
    step(.s(1));
    step(.s(1));
    chk("gate_armed", int'(o_trigger), 0);
    step(.lo(1));
    repeat (10) step(.t(1));
    step(.r(1));
    step(.s(1), .t(1), .r(1));
    chk("restart_trigger", int'(o_trigger), 1);
    chk("restart_busy", int'(o_busy), 1);
    step(.r(1));

    // Reset mid-run at count 57
    step(.s(1));
    step(.lo(1));
    repeat (57) step(.t(1));
    do_reset();
    chk("rst_trigger", int'(o_trigger), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_best", int'(o_bestTime), NONE);
    play(40);
    chk("fresh_time", int'(o_reactTime), 40);
    chk("fresh_best", int'(o_bestTime), 40);

    // Random traffic; odd blocks react rarely so timeouts occur
    for (int blk = 0; blk < 4; blk++) begin
      for (int c = 0; c < 5000; c++) begin
        bit rs, rr;
        rs = ($urandom % 40) == 0;
        rr = (blk % 2 == 0) ? (($urandom % 60) == 0) : (($urandom % 5000) == 0);
        step(.s(rs), .r(rr), .t(($urandom % 2) == 1), .lo(($urandom % 20) == 0),
             .li(($urandom % 8) != 0), .cb(($urandom % 700) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
